// File: rtl/instr_register_pkg.sv
// Shared types for instr_register and its scheduler.
// Opcode, operand, address and stored-instruction formats.
package instr_register_pkg;

  typedef enum logic [3:0] {
    ZERO, PASSA, PASSB, ADD,
    SUB, MULT, DIV, MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef logic [4:0] address_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    operand_t res;
  } instruction_t;

endpackage

// File: rtl/instr_reg_sched.sv
// Round-robin write arbiter + circular FIFO read side for instr_register.
// Define INSTR_SCHED_STATS_EN to build the per-producer grant counters.
module instr_reg_sched
  import instr_register_pkg::*;
#(
  parameter int DEPTH    = 32,
  parameter int RST_HOLD = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  input  logic         b_valid,
  output logic         a_ready,
  output logic         b_ready,
  input  opcode_t      a_opcode,
  input  opcode_t      b_opcode,
  input  operand_t     a_operand_a,
  input  operand_t     a_operand_b,
  input  operand_t     b_operand_a,
  input  operand_t     b_operand_b,
  output logic         rd_valid,
  input  logic         rd_ready,
  output instruction_t rd_data,
  input  logic         flush,
  output logic [5:0]   count,
  output logic         reg_reset_n,
  output logic         load_en,
  output opcode_t      opcode,
  output operand_t     operand_a,
  output operand_t     operand_b,
  output address_t     write_pointer,
  output address_t     read_pointer,
  input  instruction_t instruction_word,
  output logic [15:0]  grant_cnt_a,
  output logic [15:0]  grant_cnt_b
);

  typedef enum logic [1:0] {
    INIT, RUN, FLUSH
  } state_t;

  localparam int HW =
    (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_t        state;
  state_t        state_nxt;
  logic [HW-1:0] hold;
  logic          hold_done;
  logic          run;
  logic          do_flush;
  logic          space;
  logic          acc_a;
  logic          acc_b;
  logic          pop;
  logic          last_a;
  address_t      wr_ptr;
  address_t      rd_ptr;
  logic [5:0]    cnt;

  assign hold_done = (hold == HW'(RST_HOLD - 1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nxt;
  end

  // INIT dwell counter, reused on every entry
  always_ff @(posedge clk) begin
    if (reset || state != INIT || hold_done)
      hold <= '0;
    else
      hold <= hold + 1'b1;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT:    if (hold_done) state_nxt = RUN;
      RUN:     if (flush) state_nxt = FLUSH;
      FLUSH:   state_nxt = INIT;
      default: state_nxt = INIT;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    run         = (state == RUN);
    reg_reset_n = run;
    do_flush    = run & flush;
  end

  // an in-flight write already owns a slot
  assign space =
    ({1'b0, cnt} + 7'(load_en)) < 7'(DEPTH);

  assign acc_a = run & space & a_valid
               & (~b_valid | ~last_a);
  assign acc_b = run & space & b_valid
               & (~a_valid | last_a);

  assign a_ready = acc_a;
  assign b_ready = acc_b;

  assign rd_valid     = run & (|cnt);
  assign pop          = rd_valid & rd_ready;
  assign read_pointer = rd_ptr;
  assign rd_data      = instruction_word;
  assign count        = cnt;

  // capture the granted request and issue it next cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      wr_ptr        <= '0;
      last_a        <= 1'b0;
      opcode        <= ZERO;
      operand_a     <= '0;
      operand_b     <= '0;
    end else if (do_flush) begin
      load_en       <= 1'b0;
      write_pointer <= '0;
      wr_ptr        <= '0;
      last_a        <= 1'b0;
    end else begin
      load_en <= acc_a | acc_b;
      if (acc_a | acc_b) begin
        write_pointer <= wr_ptr;
        wr_ptr        <= wr_ptr + 1'b1;
        last_a        <= acc_a;
        opcode    <= acc_a ? a_opcode : b_opcode;
        operand_a <= acc_a ? a_operand_a
                           : b_operand_a;
        operand_b <= acc_a ? a_operand_b
                           : b_operand_b;
      end
    end
  end

  // occupancy tracks real register writes and pops
  always_ff @(posedge clk) begin
    if (reset || do_flush) begin
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({load_en, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef INSTR_SCHED_STATS_EN
  logic [15:0] ga;
  logic [15:0] gb;

  // saturating per-producer grant counters
  always_ff @(posedge clk) begin
    if (reset || do_flush) begin
      ga <= '0;
      gb <= '0;
    end else begin
      if (acc_a && ga != 16'hFFFF) ga <= ga + 1'b1;
      if (acc_b && gb != 16'hFFFF) gb <= gb + 1'b1;
    end
  end

  assign grant_cnt_a = ga;
  assign grant_cnt_b = gb;
`else
  assign grant_cnt_a = '0;
  assign grant_cnt_b = '0;
`endif

endmodule

// File: tb/tb_instr_reg_sched.sv
// Bench for instr_reg_sched with an instr_register stand-in.
// A queue model checks every cycle; directed steps pin literals.
module tb_instr_reg_sched;
  import instr_register_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         a_valid = 1'b0;
  logic         b_valid = 1'b0;
  logic         rd_ready = 1'b0;
  logic         flush = 1'b0;
  opcode_t      a_opcode = ZERO;
  opcode_t      b_opcode = ZERO;
  operand_t     a_operand_a = '0;
  operand_t     a_operand_b = '0;
  operand_t     b_operand_a = '0;
  operand_t     b_operand_b = '0;
  logic         a_ready;
  logic         b_ready;
  logic         rd_valid;
  instruction_t rd_data;
  logic [5:0]   count;
  logic         reg_reset_n;
  logic         load_en;
  opcode_t      opcode;
  operand_t     operand_a;
  operand_t     operand_b;
  address_t     write_pointer;
  address_t     read_pointer;
  instruction_t instruction_word;
  logic [15:0]  grant_cnt_a;
  logic [15:0]  grant_cnt_b;

  int n_chk = 0;
  int n_fail = 0;

  instr_reg_sched dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .b_valid(b_valid),
    .a_ready(a_ready), .b_ready(b_ready),
    .a_opcode(a_opcode), .b_opcode(b_opcode),
    .a_operand_a(a_operand_a),
    .a_operand_b(a_operand_b),
    .b_operand_a(b_operand_a),
    .b_operand_b(b_operand_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .flush(flush),
    .count(count), .reg_reset_n(reg_reset_n),
    .load_en(load_en), .opcode(opcode),
    .operand_a(operand_a), .operand_b(operand_b),
    .write_pointer(write_pointer),
    .read_pointer(read_pointer),
    .instruction_word(instruction_word),
    .grant_cnt_a(grant_cnt_a),
    .grant_cnt_b(grant_cnt_b)
  );

  always #5 clk = ~clk;

  function automatic instruction_t mk(
    opcode_t o, operand_t x, operand_t y);
    instruction_t r;
    r.opc  = o;
    r.op_a = x;
    r.op_b = y;
    r.res  = x + y;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // instr_register stand-in
  instruction_t mem [32];
  always @(posedge clk) begin
    if (reg_reset_n === 1'b0) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (load_en === 1'b1) begin
      mem[write_pointer] <=
        mk(opcode, operand_a, operand_b);
    end
  end
  assign instruction_word = mem[read_pointer];

  // model state
  instruction_t q[$];
  bit           infl;
  instruction_t infl_d;
  int           wp, rp, wpo, dark, ga, gb;
  bit           m_last_a;

  task automatic m_clear();
    q.delete();
    infl = 0;
    wp = 0;
    rp = 0;
    wpo = 0;
    m_last_a = 0;
    ga = 0;
    gb = 0;
  endtask

  // per-cycle compare against the model
  initial begin
    bit ea, eb, ev, ep, run, fl, rs;
    int total;
    instruction_t na, nb;
    infl_d = '0;
    @(posedge clk);
    m_clear();
    dark = 2;
    forever begin
      @(negedge clk);
      run = (dark == 0);
      total = q.size() + (infl ? 1 : 0);
      ea = run && total < 32 && a_valid
           && (!b_valid || !m_last_a);
      eb = run && total < 32 && b_valid
           && (!a_valid || m_last_a);
      ev = run && q.size() > 0;
      ep = ev && rd_ready;
      chk("m_a_ready", a_ready, ea);
      chk("m_b_ready", b_ready, eb);
      chk("m_rd_valid", rd_valid, ev);
      chk("m_reg_reset_n", reg_reset_n, run);
      chk("m_load_en", load_en, infl);
      chk("m_count", count, q.size());
      chk("m_write_pointer", write_pointer, wpo);
      chk("m_read_pointer", read_pointer, rp);
`ifdef INSTR_SCHED_STATS_EN
      chk("m_grant_a", grant_cnt_a, ga);
      chk("m_grant_b", grant_cnt_b, gb);
`else
      chk("m_grant_a", grant_cnt_a, 0);
      chk("m_grant_b", grant_cnt_b, 0);
`endif
      if (infl) begin
        chk("m_opcode", opcode, infl_d.opc);
        chk("m_operand_a", operand_a, infl_d.op_a);
        chk("m_operand_b", operand_b, infl_d.op_b);
      end
      if (ev) chk("m_rd_data", rd_data, q[0]);
      fl = flush;
      rs = reset;
      na = mk(a_opcode, a_operand_a, a_operand_b);
      nb = mk(b_opcode, b_operand_a, b_operand_b);
      @(posedge clk);
      if (rs) begin
        m_clear();
        dark = 2;
      end else if (run && fl) begin
        m_clear();
        dark = 3;
      end else begin
        if (ep) begin
          void'(q.pop_front());
          rp = (rp + 1) % 32;
        end
        if (infl) q.push_back(infl_d);
        infl = ea || eb;
        if (ea || eb) begin
          infl_d = ea ? na : nb;
          wpo = wp;
          wp = (wp + 1) % 32;
          m_last_a = ea;
          if (ea && ga < 65535) ga++;
          if (eb && gb < 65535) gb++;
        end
        if (dark > 0) dark--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(opcode_t o, int x, int y);
    a_opcode = o;
    a_operand_a = x;
    a_operand_b = y;
  endtask

  opcode_t  t_opc [5] = '{ADD, SUB, MULT, PASSA, DIV};
  int       t_a   [5] = '{3, 10, 5, 7, 9};
  int       t_b   [5] = '{4, 2, 6, 0, 3};

  // directed stimulus with literal expectations
  initial begin
    string g;
    int n;
    a_valid = 1'b1;
    set_a(t_opc[0], t_a[0], t_b[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reg_reset_n", reg_reset_n, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_count", count, 0);
    chk("rst_write_pointer", write_pointer, 0);
    chk("rst_read_pointer", read_pointer, 0);
    chk("rst_opcode", opcode, ZERO);
    chk("rst_operand_a", operand_a, 0);
    chk("rst_a_ready", a_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_grant_a", grant_cnt_a, 0);
    reset = 1'b0;
    #1;
    chk("init_c1_ready", a_ready, 0);
    chk("init_c1_rrn", reg_reset_n, 0);
    tick();
    chk("init_c2_ready", a_ready, 0);
    chk("init_c2_rrn", reg_reset_n, 0);
    tick();
    chk("run_c3_rrn", reg_reset_n, 1);
    for (int i = 0; i < 5; i++) begin
      set_a(t_opc[i], t_a[i], t_b[i]);
      chk("a_only_ready", a_ready, 1);
      tick();
    end
    a_valid = 1'b0;
    tick();
    chk("a_only_count", count, 5);
    chk("a_only_head_opc", rd_data.opc, ADD);
    chk("a_only_head_a", rd_data.op_a, 3);
    chk("a_only_head_b", rd_data.op_b, 4);
    rd_ready = 1'b1;
    repeat (5) tick();
    rd_ready = 1'b0;
    chk("a_only_drained", rd_valid, 0);
    chk("a_only_cnt0", count, 0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    chk("rr_run", reg_reset_n, 1);
    a_valid = 1'b1;
    b_valid = 1'b1;
    g = "";
    for (int i = 0; i < 6; i++) begin
      set_a(ADD, 20 + i, 1);
      b_opcode = SUB;
      b_operand_a = 100 + i;
      b_operand_b = 2;
      #1;
      if (a_ready) g = {g, "A"};
      else if (b_ready) g = {g, "B"};
      else g = {g, "-"};
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    n_chk++;
    if (g != "ABABAB") begin
      n_fail++;
      $display("FAIL rr_order: got %s expected ABABAB",
               g);
    end
    tick();
    tick();
    chk("rr_count", count, 6);
`ifdef INSTR_SCHED_STATS_EN
    chk("rr_grant_a", grant_cnt_a, 3);
    chk("rr_grant_b", grant_cnt_b, 3);
`else
    chk("rr_grant_a", grant_cnt_a, 0);
    chk("rr_grant_b", grant_cnt_b, 0);
`endif
    a_valid = 1'b1;
    set_a(MOD, 77, 1);
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    chk("fl_pre_count", count, 7);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_count", count, 0);
    chk("fl_rd_valid", rd_valid, 0);
    chk("fl_rrn1", reg_reset_n, 0);
    chk("fl_grant_a", grant_cnt_a, 0);
    tick();
    chk("fl_rrn2", reg_reset_n, 0);
    tick();
    chk("fl_rrn3", reg_reset_n, 0);
    tick();
    chk("fl_rrn_run", reg_reset_n, 1);
    chk("fl_wp", write_pointer, 0);
    chk("fl_rp", read_pointer, 0);

    a_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_a(PASSB, i, 2 * i);
      tick();
    end
    chk("full_count", count, 32);
    chk("full_ready", a_ready, 0);
    chk("full_wp", write_pointer, 31);
    chk("full_rp", read_pointer, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    set_a(MOD, 555, 5);
    #1;
    chk("wrap_ready", a_ready, 1);
    tick();
    chk("wrap_load", load_en, 1);
    chk("wrap_wp", write_pointer, 0);
    chk("wrap_rp", read_pointer, 1);
    chk("wrap_ready0", a_ready, 0);
    tick();
    tick();
    chk("wrap_count", count, 32);
    chk("wrap_still_full", a_ready, 0);
    a_valid = 1'b0;

    rd_ready = 1'b1;
    n = 0;
    while (count > 4 && n < 100) begin
      tick();
      n++;
    end
    rd_ready = 1'b0;
    chk("drain_to4", count, 4);

    a_valid = 1'b1;
    set_a(SUB, 1000, 1);
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      set_a(opcode_t'(i % 8), 2000 + i, i);
      chk("steady_count", count, 4);
      tick();
    end
    a_valid = 1'b0;
    n = 0;
    while (rd_valid && n < 20) begin
      tick();
      n++;
    end
    tick();
    rd_ready = 1'b0;
    chk("steady_drained", count, 0);
    chk("steady_rd_valid", rd_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_reg_sched.md
# instr_reg_sched

Write/read scheduler for `instr_register`: arbitrates two instruction producers onto the register's single write port (round-robin) and uses the 32-entry register file as a circular FIFO towards one consumer. It also sequences the register's own reset (`reset_n`). It sits between the stimulus/issue logic and `instr_register`, and reuses `instr_register_pkg` types.

## Interface
- `DEPTH`, 32: entries used; must equal 2**$bits(address_t).
- `RST_HOLD`, 2: cycles `reg_reset_n` is held low after reset or flush.

Ports:
- `clk`  in  1  clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `a_valid`, `b_valid`  in  1  producer A/B request.
- `a_ready`, `b_ready`  out  1  producer A/B accepted this cycle.
- `a_opcode`, `b_opcode`  in  opcode_t  instruction opcode.
- `a_operand_a`, `a_operand_b`, `b_operand_a`, `b_operand_b`  in  operand_t  operands.
- `rd_valid`  out  1  head entry available.
- `rd_ready`  in  1  consumer pops head.
- `rd_data`  out  instruction_t  head entry (opc, op_a, op_b, res).
- `flush`  in  1  discard all entries and re-reset the register.
- `count`  out  6  entries stored (0..32).
- `reg_reset_n`, `load_en`  out  1  to instr_register.
- `opcode`, `operand_a`, `operand_b`, `write_pointer`, `read_pointer`  out  pkg types  to instr_register.
- `instruction_word`  in  instruction_t  from instr_register.
- `grant_cnt_a`, `grant_cnt_b`  out  16  accepted-write counters (see Configuration).

## Operation
- FSM states: INIT, RUN, FLUSH.
- INIT: `reg_reset_n`=0 for RST_HOLD cycles. Both readys=0, `rd_valid`=0. Then go to RUN.
- RUN: normal operation. `flush`=1 in RUN → FLUSH.
- FLUSH: 1 cycle. Pointers, `count` and the pending write are cleared, `reg_reset_n`=0. Then go to INIT.
- `flush` is ignored outside RUN.
- Arbitration:
  - Only one write is accepted per cycle, and only when space is free.
  - Space is free when `count` + `load_en` < DEPTH.
  - If one producer is valid, it is granted.
  - If both are valid, the producer not granted last time wins. `last` resets to B, so A wins first.
  - `x_ready` is combinational from valid/space/`last`. Accept = `x_valid` & `x_ready`.
- Write issue: on accept, the next cycle drives `load_en`=1, `write_pointer`=`wr_ptr` and the registered operands/opcode. `wr_ptr` increments mod DEPTH. Without an accept, `load_en`=0 and the data outputs hold.
- `count` increments on the edge where `load_en`=1 (the actual register write).
- Read side:
  - `read_pointer` = `rd_ptr`. `rd_data` = `instruction_word` (combinational pass-through).
  - `rd_valid` = (`count`≠0) in RUN.
  - Pop (`rd_valid` & `rd_ready`): `rd_ptr` increments mod DEPTH and `count` decrements.
- Write and pop on the same edge: `count` is unchanged.
- Wrap-around: both pointers wrap from 31 to 0. FIFO order is preserved across the wrap.
- `reset` mid-operation has the same effect as FLUSH but enters INIT directly. Stored data is discarded.

## Timing
- Reset values:
  - state=INIT, `reg_reset_n`=0, `load_en`=0.
  - `write_pointer`=0, `read_pointer`=0, `count`=0.
  - opcode=ZERO, operands=0.
  - readys=0, `rd_valid`=0, grant counters=0.
- Write latency: accept at edge N → `load_en`=1 during cycle N+1 → register written at edge N+1 → `rd_valid` from cycle N+1 after the edge (earliest pop at edge N+2).
- The `res` field is whatever the register computes. The scheduler does not evaluate it.
- Full: `count`=31 with `load_en`=1 blocks a new accept. At `count`=32 both readys are 0 until a pop.
- Empty: `rd_ready` with `rd_valid`=0 has no effect.
- Sustained throughput is one write and one pop per cycle.

## Configuration
- `INSTR_SCHED_STATS_EN` defined:
  - `grant_cnt_a`/`grant_cnt_b` count accepted writes per producer.
  - The counters saturate at 16'hFFFF and clear on `reset` and on FLUSH.
- Not defined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset held 3 cycles then released → `reg_reset_n` low until 2 cycles after release. Readys are 0 during INIT, and the first accept is possible in cycle 3 after release.
- A only, 5 writes (ADD 3,4 … ) → `write_pointer` 0..4, `count`=5. Reads return the same opc/op_a/op_b in order, and `rd_valid` drops after the 5th pop.
- A and B both valid for 6 cycles → grants alternate A,B,A,B,A,B. With STATS: `grant_cnt_a`=3, `grant_cnt_b`=3.
- Fill 32 entries with no pops → `count`=32, readys=0. One pop → exactly one more accept, which goes to `write_pointer`=0 (wrap). Read order continues at `read_pointer`=1.
- Continuous write+pop with `count`=4 for 40 cycles → `count` stays 4. Both pointers wrap, and data order is intact.
- `flush` with `count`=7 → next cycle `count`=0, `rd_valid`=0, `reg_reset_n` low for 3 cycles (FLUSH + 2 INIT). Pointers restart at 0.
